adder_datapath: RTL and testbench

- Datapath responder to the adder control path: consumes the lda/ldb/ldc load strobes and performs the registered loads and addition.
- Loads operand A, then operand B, from a shared input bus, then captures A+B into result register C.
- Tracks the strobe sequence, reports completion (done) and protocol violations (seq_err) back to the controller or a monitor.
- Sits beside control_path in the adder top level; the strobes connect one-to-one.

---
 rtl/adder_datapath_pkg.sv | 18 +
 rtl/adder_datapath_ld_seq_tracker.sv | 85 ++++++++
 rtl/adder_datapath.sv | 70 +++++++
 tb/tb_adder_datapath.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/adder_datapath_pkg.sv
// Shared definitions for the adder datapath: load-sequence tracker state
// encodings and a small strobe-decoding helper.
package adder_datapath_pkg;

  // Gray-style encoding shared with the control path: IDLE -> GOT_A -> GOT_B
  // changes one bit per legal step.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GOT_A = 2'b01,
    GOT_B = 2'b11
  } trk_state_e;

  // True when two or more of the three load strobes are high together.
  function automatic logic multi_hot3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/adder_datapath_ld_seq_tracker.sv
// Load-sequence tracker: follows the lda -> ldb -> ldc strobe order, pulses
// done on a completed sequence and raises a sticky seq_err on any violation.
//
// Strobe protocol: lda/ldb/ldc are single-cycle commands sampled on the rising
// clock edge. There is no back-pressure; exactly one strobe high in a cycle is
// a legal command, none high is an idle cycle, more than one is a violation
// that performs no load.
module adder_datapath_ld_seq_tracker
  import adder_datapath_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       lda,
  input  logic       ldb,
  input  logic       ldc,
  input  logic       clr_err,
  output logic       done,
  output logic       busy,
  output logic       seq_err,
  output logic       multi_strobe,
  output trk_state_e state_o
);

  trk_state_e state_q, state_d;
  logic       done_q, done_d;
  logic       seq_err_q, seq_err_d;
  logic       err_set;

  assign multi_strobe = multi_hot3(lda, ldb, ldc);

  // Next-state, done and error decode from the current state and strobes.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_set = 1'b0;
    if (multi_strobe) begin
      state_d = IDLE;
      err_set = 1'b1;
    end else if (lda) begin
      // lda always (re)starts a sequence, never an error.
      state_d = GOT_A;
    end else if (ldb) begin
      if (state_q == GOT_A) begin
        state_d = GOT_B;
      end else begin
        state_d = IDLE;
        err_set = 1'b1;
      end
    end else if (ldc) begin
      state_d = IDLE;
      if (state_q == GOT_B) begin
        done_d = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end
    // A new violation wins over a simultaneous clear.
    if (err_set) begin
      seq_err_d = 1'b1;
    end else if (clr_err) begin
      seq_err_d = 1'b0;
    end else begin
      seq_err_d = seq_err_q;
    end
  end

  // Tracker state, registered done pulse and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign done    = done_q;
  assign busy    = (state_q != IDLE);
  assign seq_err = seq_err_q;
  assign state_o = state_q;

endmodule

// File: rtl/adder_datapath.sv
// Adder datapath: loads operands A and B from a shared bus and captures the
// (WIDTH+1)-bit sum into C under control of the lda/ldb/ldc strobes.
module adder_datapath
  import adder_datapath_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             lda,
  input  logic             ldb,
  input  logic             ldc,
  input  logic             clr_err,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done,
  output logic             busy,
  output logic             seq_err,
  output trk_state_e       dbg_state
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   c_q, c_d;
  logic             multi_strobe;

  adder_datapath_ld_seq_tracker u_tracker (
    .clk          (clk),
    .rst          (rst),
    .lda          (lda),
    .ldb          (ldb),
    .ldc          (ldc),
    .clr_err      (clr_err),
    .done         (done),
    .busy         (busy),
    .seq_err      (seq_err),
    .multi_strobe (multi_strobe),
    .state_o      (dbg_state)
  );

  // Register loads; out-of-order strobes still load, simultaneous ones do not.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    if (!multi_strobe) begin
      if (lda) a_d = data_in;
      if (ldb) b_d = data_in;
      if (ldc) c_d = {1'b0, a_q} + {1'b0, b_q};
    end
  end

  // Operand and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  end

  assign sum  = c_q[WIDTH-1:0];
  assign cout = c_q[WIDTH];

endmodule

// File: tb/tb_adder_datapath.sv
// Directed bench for adder_datapath with a result scoreboard.
module tb_adder_datapath;
  import adder_datapath_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] data_in;
  logic         lda, ldb, ldc, clr_err;
  logic [W-1:0] sum;
  logic         cout, done, busy, seq_err;
  trk_state_e   dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference operand values and last captured result.
  logic [W-1:0] a_m, b_m;
  logic [W:0]   c_last;
  logic [W:0]   exp_q[$];

  adder_datapath #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .lda       (lda),
    .ldb       (ldb),
    .ldc       (ldc),
    .clr_err   (clr_err),
    .sum       (sum),
    .cout      (cout),
    .done      (done),
    .busy      (busy),
    .seq_err   (seq_err),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: apply one cycle of strobes, then check flags and the result.
  task automatic step(input string tag, input logic a, input logic b, input logic c,
                      input logic clr, input logic [W-1:0] d,
                      input logic e_done, input logic e_busy, input logic e_err);
    logic       single;
    logic [W:0] exp_c;
    @(negedge clk);
    lda     = a;
    ldb     = b;
    ldc     = c;
    clr_err = clr;
    data_in = (a | b) ? d : W'($urandom_range(0, 255));
    single  = (32'(a) + 32'(b) + 32'(c)) == 1;
    if (single && c) exp_q.push_back({1'b0, a_m} + {1'b0, b_m});
    if (single && a) a_m = d;
    if (single && b) b_m = d;
    @(posedge clk);
    #1;
    lda = 1'b0; ldb = 1'b0; ldc = 1'b0; clr_err = 1'b0;
    chk({tag, ".done"},    16'(done),    16'(e_done));
    chk({tag, ".busy"},    16'(busy),    16'(e_busy));
    chk({tag, ".seq_err"}, 16'(seq_err), 16'(e_err));
    if (single && c) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".sb_empty"}, 16'd1, 16'd0);
      end else begin
        exp_c  = exp_q.pop_front();
        c_last = exp_c;
      end
    end
    chk({tag, ".result"}, 16'({cout, sum}), 16'(c_last));
  endtask

  initial begin
    rst = 1'b0; lda = 0; ldb = 0; ldc = 0; clr_err = 0; data_in = '0;
    a_m = '0; b_m = '0; c_last = '0;
    #12;
    chk("reset.sum",     16'(sum),       16'h0);
    chk("reset.cout",    16'(cout),      16'h0);
    chk("reset.done",    16'(done),      16'h0);
    chk("reset.busy",    16'(busy),      16'h0);
    chk("reset.seq_err", 16'(seq_err),   16'h0);
    chk("reset.state",   16'(dbg_state), 16'(IDLE));
    @(negedge clk);
    rst = 1'b1;

    // Normal sequence: 3C + 25 = 61
    step("norm.lda",  1, 0, 0, 0, 8'h3C, 0, 1, 0);
    chk("norm.state_a", 16'(dbg_state), 16'(GOT_A));
    step("norm.ldb",  0, 1, 0, 0, 8'h25, 0, 1, 0);
    chk("norm.state_b", 16'(dbg_state), 16'(GOT_B));
    step("norm.ldc",  0, 0, 1, 0, 8'h00, 1, 0, 0);
    chk("norm.sum_const", 16'({cout, sum}), 16'h061);
    step("norm.idle", 0, 0, 0, 0, 8'h00, 0, 0, 0);

    // Overflow: FF + 01
    step("ovf.lda",  1, 0, 0, 0, 8'hFF, 0, 1, 0);
    step("ovf.ldb",  0, 1, 0, 0, 8'h01, 0, 1, 0);
    step("ovf.ldc",  0, 0, 1, 0, 8'h00, 1, 0, 0);
    chk("ovf.sum_const", 16'({cout, sum}), 16'h100);
    step("ovf.idle", 0, 0, 0, 0, 8'h00, 0, 0, 0);

    // Out of order ldb from IDLE, then clear, then a legal sequence
    step("ooo.ldb",  0, 1, 0, 0, 8'h11, 0, 0, 1);
    step("ooo.hold", 0, 0, 0, 0, 8'h00, 0, 0, 1);
    step("ooo.clr",  0, 0, 0, 1, 8'h00, 0, 0, 0);
    step("ooo.lda",  1, 0, 0, 0, 8'h02, 0, 1, 0);
    step("ooo.ldb",  0, 1, 0, 0, 8'h03, 0, 1, 0);
    step("ooo.ldc",  0, 0, 1, 0, 8'h00, 1, 0, 0);

    // Simultaneous strobes: no load; then ldc+clr_err in IDLE keeps error
    step("sim.lda",    1, 0, 0, 0, 8'h10, 0, 1, 0);
    step("sim.ldab",   1, 1, 0, 0, 8'hAA, 0, 0, 1);
    chk("sim.state",   16'(dbg_state), 16'(IDLE));
    step("sim.ldcclr", 0, 0, 1, 1, 8'h00, 0, 0, 1);
    chk("sim.sum_const", 16'({cout, sum}), 16'h013);
    step("sim.nodone", 0, 0, 0, 0, 8'h00, 0, 0, 1);
    step("sim.clr",    0, 0, 0, 1, 8'h00, 0, 0, 0);

    // Restart with a second lda
    step("rst.lda1", 1, 0, 0, 0, 8'h05, 0, 1, 0);
    step("rst.lda2", 1, 0, 0, 0, 8'h07, 0, 1, 0);
    step("rst.ldb",  0, 1, 0, 0, 8'h01, 0, 1, 0);
    step("rst.ldc",  0, 0, 1, 0, 8'h00, 1, 0, 0);
    chk("rst.sum_const", 16'({cout, sum}), 16'h008);

    // Asynchronous reset after ldb discards the sequence
    step("ar.lda", 1, 0, 0, 0, 8'h09, 0, 1, 0);
    step("ar.ldb", 0, 1, 0, 0, 8'h04, 0, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("ar.sum",     16'(sum),       16'h0);
    chk("ar.cout",    16'(cout),      16'h0);
    chk("ar.done",    16'(done),      16'h0);
    chk("ar.busy",    16'(busy),      16'h0);
    chk("ar.seq_err", 16'(seq_err),   16'h0);
    chk("ar.state",   16'(dbg_state), 16'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    a_m = '0; b_m = '0; c_last = '0;
    step("ar.ldc",  0, 0, 1, 0, 8'h00, 0, 0, 1);
    step("ar.idle", 0, 0, 0, 0, 8'h00, 0, 0, 1);

    if (exp_q.size() != 0) chk("sb.leftover", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
